// File: rtl/mmio_monitor_pkg.sv
// Shared types and helpers for the MMIO bus monitor: FSM state encoding,
// the captured log entry layout and saturating counter increments.
package mmio_monitor_pkg;

  // Default bus widths used by the log entry layout.
  localparam int LOG_ADDR_W = 32;
  localparam int LOG_DATA_W = 32;

  // Monitor run state. HALT and TIMEOUT are terminal until reset.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALT    = 2'd1,
    ST_TIMEOUT = 2'd2
  } monState_t;

  // One captured MMIO store.
  typedef struct packed {
    logic [LOG_ADDR_W-1:0] addr;
    logic [LOG_DATA_W-1:0] data;
  } logEntry_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  // 32-bit variant for the cycle counter.
  function automatic logic [31:0] satInc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/mmio_monitor_if.sv
// Shared core/memory bus as seen by the monitor plus the log drain port.
// The master side is whoever drives the bus and consumes the log; the
// slave side is the monitor itself.
interface mmio_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_out;
  logic              we;
  logic              log_valid;
  logic              log_ready;
  logic [ADDR_W-1:0] log_addr;
  logic [DATA_W-1:0] log_data;

  modport master (
    output address, data_out, we, log_ready,
    input  log_valid, log_addr, log_data
  );

  modport slave (
    input  address, data_out, we, log_ready,
    output log_valid, log_addr, log_data
  );

endinterface

// File: rtl/mmio_monitor_sync_fifo.sv
// Small synchronous FIFO with one extra pointer bit to tell full from
// empty. In first-word-fall-through mode the head entry is presented on
// o_rdata as soon as it is written; otherwise o_rdata is loaded on pop.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  parameter bit FWFT  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic             w_full;
  logic             w_empty;
  logic             w_rdEn;
  logic             w_wrEn;

  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_rdEn  = i_pop && !w_empty;
  assign w_wrEn  = i_push && (!w_full || w_rdEn);

  assign o_full  = w_full;
  assign o_empty = w_empty;

  // Storage and pointers; reset wipes contents so the head reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wrEn) begin
        r_mem[r_wrPtr[AW-1:0]] <= i_wdata;
        r_wrPtr                <= r_wrPtr + 1'b1;
      end
      if (w_rdEn) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign o_rdata = r_mem[r_rdPtr[AW-1:0]];
    end else begin : g_std
      logic [WIDTH-1:0] r_rdata;

      // Registered read data, updated only when an entry is popped.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_rdata <= '0;
        end else if (w_rdEn) begin
          r_rdata <= r_mem[r_rdPtr[AW-1:0]];
        end
      end

      assign o_rdata = r_rdata;
    end
  endgenerate

endmodule

// File: rtl/mmio_monitor.sv
// Passive observer of the core/memory bus. Ends the run when the halt
// address shows up, stops it when the cycle budget runs out, and logs
// every store into the MMIO window into a FIFO drained via valid/ready.
module mmio_monitor
  import mmio_monitor_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR  = 32'h0000_0FFC,
  parameter logic [ADDR_W-1:0] MMIO_MASK  = 32'h0000_0800,
  parameter int unsigned       TIMEOUT    = 2000,
  parameter int                FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_monitor_if.slave        bus,
  output logic                 halted,
  output logic                 timed_out,
  output logic [31:0]          cycle_count,
  output logic [15:0]          store_count,
  output logic [15:0]          drop_count
);

  localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_EN ? 32'(TIMEOUT - 1) : 32'd0;
  localparam int          ENTRY_W      = ADDR_W + DATA_W;

  monState_t          r_state;
  logic               r_halted;
  logic               r_timedOut;
  logic [31:0]        r_cycleCount;
  logic [15:0]        r_storeCount;
  logic [15:0]        r_dropCount;

  logic               w_running;
  logic               w_haltHit;
  logic               w_timeoutHit;
  logic               w_capture;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;

  // Halt wins over the watchdog, and a halt access is never logged even
  // though the halt address sits inside the MMIO window. The access in the
  // watchdog's final cycle is still a normal RUN cycle and gets logged.
  assign w_running    = (r_state == ST_RUN);
  assign w_haltHit    = w_running && (bus.address == HALT_ADDR);
  assign w_timeoutHit = w_running && !w_haltHit && TIMEOUT_EN &&
                        (r_cycleCount == TIMEOUT_LAST);
  assign w_capture    = w_running && !w_haltHit && bus.we &&
                        ((bus.address & MMIO_MASK) != '0);

  // Pop first, then push, so a full FIFO still takes a store when drained.
  assign w_pop   = !w_empty && bus.log_ready;
  assign w_push  = w_capture && (!w_full || w_pop);
  assign w_drop  = w_capture && !w_push;
  assign w_wdata = {bus.address, bus.data_out};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .FWFT  (1'b1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Run-state machine with sticky registered halted / timed_out flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_halted   <= 1'b0;
      r_timedOut <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_haltHit) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (w_timeoutHit) begin
            r_state    <= ST_TIMEOUT;
            r_timedOut <= 1'b1;
          end
        end
        ST_HALT:    r_state <= ST_HALT;
        ST_TIMEOUT: r_state <= ST_TIMEOUT;
        default:    r_state <= ST_RUN;
      endcase
    end
  end

  // Saturating statistics: RUN cycles, accepted and dropped MMIO stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycleCount <= '0;
      r_storeCount <= '0;
      r_dropCount  <= '0;
    end else begin
      if (w_running) begin
        r_cycleCount <= satInc32(r_cycleCount);
      end
      if (w_push) begin
        r_storeCount <= satInc16(r_storeCount);
      end
      if (w_drop) begin
        r_dropCount <= satInc16(r_dropCount);
      end
    end
  end

  assign bus.log_valid = !w_empty;
  assign bus.log_addr  = w_rdata[DATA_W +: ADDR_W];
  assign bus.log_data  = w_rdata[DATA_W-1:0];

  assign halted      = r_halted;
  assign timed_out   = r_timedOut;
  assign cycle_count = r_cycleCount;
  assign store_count = r_storeCount;
  assign drop_count  = r_dropCount;

endmodule

// File: tb/tb_mmio_monitor.sv
// Bench for mmio_monitor. Instance A (default budget) is checked every
// cycle against a behavioural model whose expected log entries live in a
// scoreboard queue; instance B (budget of 20 cycles) covers the watchdog.
module tb_mmio_monitor;
  import mmio_monitor_pkg::*;

  localparam int unsigned TO_A  = 2000;
  localparam int unsigned TO_B  = 20;
  localparam int          DEPTH = 8;

  logic        clk;
  logic        resetA;
  logic        resetB;
  logic        haltedA, timedOutA, haltedB, timedOutB;
  logic [31:0] cycleA, cycleB;
  logic [15:0] storeA, dropA, storeB, dropB;

  int vectors;
  int miscompares;

  logEntry_t   expQ[$];
  logic        mRun;
  logic        mHalted;
  logic        mTimedOut;
  logic [31:0] mCycle;
  logic [15:0] mStore;
  logic [15:0] mDrop;

  mmio_monitor_if busA ();
  mmio_monitor_if busB ();

  mmio_monitor #(.TIMEOUT(TO_A), .FIFO_DEPTH(DEPTH)) u_dutA (
    .clk         (clk),
    .reset       (resetA),
    .bus         (busA),
    .halted      (haltedA),
    .timed_out   (timedOutA),
    .cycle_count (cycleA),
    .store_count (storeA),
    .drop_count  (dropA)
  );

  mmio_monitor #(.TIMEOUT(TO_B), .FIFO_DEPTH(DEPTH)) u_dutB (
    .clk         (clk),
    .reset       (resetB),
    .bus         (busB),
    .halted      (haltedB),
    .timed_out   (timedOutB),
    .cycle_count (cycleB),
    .store_count (storeB),
    .drop_count  (dropB)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare instance A with the model, then advance DUT and model one edge.
  task automatic clockOne();
    logEntry_t head;
    bit        pop;
    bit        full;
    bit        haltHit;
    bit        toHit;
    bit        cap;
    checkOutput("A.log_valid", 32'(busA.log_valid), 32'(expQ.size() != 0));
    checkOutput("A.halted", 32'(haltedA), 32'(mHalted));
    checkOutput("A.timed_out", 32'(timedOutA), 32'(mTimedOut));
    checkOutput("A.cycle_count", cycleA, mCycle);
    checkOutput("A.store_count", 32'(storeA), 32'(mStore));
    checkOutput("A.drop_count", 32'(dropA), 32'(mDrop));
    full = (expQ.size() == DEPTH);
    pop  = (expQ.size() != 0) && (busA.log_ready === 1'b1);
    if (pop) begin
      head = expQ.pop_front();
      checkOutput("A.log_addr", busA.log_addr, head.addr);
      checkOutput("A.log_data", busA.log_data, head.data);
    end
    if (resetA) begin
      expQ.delete();
      mRun = 1'b1; mHalted = 1'b0; mTimedOut = 1'b0;
      mCycle = '0; mStore = '0; mDrop = '0;
    end else if (mRun) begin
      haltHit = (busA.address == 32'h0000_0FFC);
      toHit   = !haltHit && (TO_A != 0) && (mCycle == 32'(TO_A - 1));
      cap     = !haltHit && busA.we && ((busA.address & 32'h0000_0800) != 0);
      if (mCycle != 32'hFFFF_FFFF) mCycle = mCycle + 1;
      if (cap) begin
        if (!full || pop) begin
          expQ.push_back('{addr: busA.address, data: busA.data_out});
          if (mStore != 16'hFFFF) mStore = mStore + 1;
        end else if (mDrop != 16'hFFFF) begin
          mDrop = mDrop + 1;
        end
      end
      if (haltHit) begin
        mRun = 1'b0; mHalted = 1'b1;
      end else if (toHit) begin
        mRun = 1'b0; mTimedOut = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic [31:0] addr, input logic [31:0] data,
                               input logic weV, input logic readyV);
    resetA            = rst;
    busA.address      = addr;
    busA.data_out     = data;
    busA.we           = weV;
    busA.log_ready    = readyV;
    clockOne();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetA = 1'b1;
    resetB = 1'b1;
    busA.address = '0; busA.data_out = '0; busA.we = 1'b0; busA.log_ready = 1'b0;
    busB.address = '0; busB.data_out = '0; busB.we = 1'b0; busB.log_ready = 1'b0;
    mRun = 1'b1; mHalted = 1'b0; mTimedOut = 1'b0;
    mCycle = '0; mStore = '0; mDrop = '0;
    @(posedge clk);
    #1;

    // Reset held for 5 cycles, then reset values.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("rst.log_valid", 32'(busA.log_valid), 32'd0);
    checkOutput("rst.log_addr", busA.log_addr, 32'd0);
    checkOutput("rst.log_data", busA.log_data, 32'd0);
    checkOutput("rst.halted", 32'(haltedA), 32'd0);
    checkOutput("rst.timed_out", 32'(timedOutA), 32'd0);
    checkOutput("rst.cycle_count", cycleA, 32'd0);

    // Two MMIO stores, held in the FIFO, then drained in order.
    applyStimulus(1'b0, 32'h804, 32'd7, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h808, 32'd9, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'd0, 1'b0, 1'b0);
    checkOutput("two.store_count", 32'(storeA), 32'd2);
    checkOutput("two.head_addr", busA.log_addr, 32'h804);
    checkOutput("two.head_data", busA.log_data, 32'd7);
    checkOutput("two.halted", 32'(haltedA), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Non-MMIO store and MMIO read leave nothing behind.
    applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h004, 32'd3, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h800, 32'd4, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("nolog.store_count", 32'(storeA), 32'd0);
    checkOutput("nolog.log_valid", 32'(busA.log_valid), 32'd0);

    // Halt address on the 37th RUN cycle, with we high.
    applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 36; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'hFFC, 32'hAB, 1'b1, 1'b1);
    checkOutput("halt.halted", 32'(haltedA), 32'd1);
    checkOutput("halt.cycle_count", cycleA, 32'd37);
    checkOutput("halt.log_valid", 32'(busA.log_valid), 32'd0);
    applyStimulus(1'b0, 32'h804, 32'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h808, 32'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("halt.store_frozen", 32'(storeA), 32'd0);
    checkOutput("halt.cycle_frozen", cycleA, 32'd37);
    checkOutput("halt.timed_out", 32'(timedOutA), 32'd0);

    // Overfill: 10 stores into 8 entries, then a store with a pop at full.
    applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 32'h800 + 32'(4 * i), 32'(100 + i), 1'b1, 1'b0);
    checkOutput("fill.store_count", 32'(storeA), 32'd8);
    checkOutput("fill.drop_count", 32'(dropA), 32'd2);
    applyStimulus(1'b0, 32'h8F0, 32'hBEEF, 1'b1, 1'b1);
    checkOutput("fill.pushpop_store", 32'(storeA), 32'd9);
    checkOutput("fill.pushpop_drop", 32'(dropA), 32'd2);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("fill.drained", 32'(busA.log_valid), 32'd0);

    // Reset with pending entries and halted set.
    applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 32'h810 + 32'(4 * i), 32'(i + 1), 1'b1, 1'b0);
    applyStimulus(1'b0, 32'hFFC, 32'h0, 1'b0, 1'b0);
    checkOutput("mid.halted_set", 32'(haltedA), 32'd1);
    applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("mid.log_valid", 32'(busA.log_valid), 32'd0);
    checkOutput("mid.halted", 32'(haltedA), 32'd0);
    checkOutput("mid.store_count", 32'(storeA), 32'd0);
    checkOutput("mid.cycle_count", cycleA, 32'd0);
    applyStimulus(1'b0, 32'h804, 32'd5, 1'b1, 1'b0);
    checkOutput("mid.running", 32'(storeA), 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Watchdog on instance B: store in the last budget cycle is still logged.
    resetB = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    checkOutput("to.early_flag", 32'(timedOutB), 32'd0);
    checkOutput("to.early_cycle", cycleB, 32'd19);
    busB.address = 32'h810; busB.data_out = 32'h55; busB.we = 1'b1;
    @(posedge clk);
    #1;
    busB.address = 32'h820; busB.data_out = 32'h66;
    checkOutput("to.timed_out", 32'(timedOutB), 32'd1);
    checkOutput("to.cycle_count", cycleB, 32'd20);
    checkOutput("to.halted", 32'(haltedB), 32'd0);
    checkOutput("to.last_logged", 32'(busB.log_valid), 32'd1);
    checkOutput("to.last_addr", busB.log_addr, 32'h810);
    checkOutput("to.last_data", busB.log_data, 32'h55);
    repeat (5) @(posedge clk);
    #1;
    busB.we = 1'b0;
    checkOutput("to.cycle_frozen", cycleB, 32'd20);
    checkOutput("to.store_count", 32'(storeB), 32'd1);
    checkOutput("to.still_flag", 32'(timedOutB), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
